// File: rtl/onehot_sequencer.sv
// Registered one-hot sequencer: an index register stepped, loaded or auto-advanced,
// with its decode on X. Defining ONEHOT_SEQ_THERMO_EN adds MODE for a thermometer decode.
`timescale 1ns/1ps
module onehot_sequencer #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL   = 1,
  parameter int unsigned RST_IDX = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic                    LOAD,
  input  logic [SEL_W-1:0]        SEL,
  input  logic                    STEP,
  input  logic                    DIR,
  input  logic                    RUN,
`ifdef ONEHOT_SEQ_THERMO_EN
  input  logic                    MODE,
`endif
  output logic [(1 << SEL_W)-1:0] X,
  output logic [SEL_W-1:0]        IDX,
  output logic                    WRAP
);

  localparam int unsigned OUT_W = 1 << SEL_W;
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [OUT_W-1:0] x_q, x_d;
  logic [OUT_W-1:0] onehot;
  logic             advance;
`ifdef ONEHOT_SEQ_THERMO_EN
  logic [OUT_W:0]   thermo_ext;
`endif

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = '0;
    wrap_d  = 1'b0;
    advance = 1'b0;

    if (LOAD) begin
      idx_d = SEL;
    end else if (STEP) begin
      advance = 1'b1;
    end else if (RUN) begin
      if (cnt_q == DWELL_LAST) begin
        advance = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Index arithmetic wraps naturally modulo OUT_W; flag the wrap edge explicitly.
    if (advance) begin
      if (DIR) begin
        idx_d  = idx_q - 1'b1;
        wrap_d = (idx_q == '0);
      end else begin
        idx_d  = idx_q + 1'b1;
        wrap_d = &idx_q;
      end
    end

    onehot        = '0;
    onehot[idx_d] = 1'b1;

`ifdef ONEHOT_SEQ_THERMO_EN
    // Shifting the one-hot up and subtracting one sets every bit at or below idx_d.
    thermo_ext = {onehot, 1'b0} - (OUT_W + 1)'(1);
    x_d        = EN ? (MODE ? thermo_ext[OUT_W-1:0] : onehot) : '0;
`else
    x_d = EN ? onehot : '0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q  <= SEL_W'(RST_IDX);
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      x_q    <= '0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      x_q    <= x_d;
    end
  end

  assign X    = x_q;
  assign IDX  = idx_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_onehot_sequencer.sv
// Self-checking bench for onehot_sequencer (SEL_W=3, DWELL=3, RST_IDX=0): each cycle's
// expected X/IDX/WRAP is queued as stimulus is applied and popped after the clock edge.
`timescale 1ns/1ps
module tb_onehot_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, load, step, dir, run, mode;
  logic [2:0] sel;
  logic [7:0] x;
  logic [2:0] idx;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rst, load;
    logic [2:0] sel;
    logic       step, dir, run, en, mode;
    logic [7:0] x;
    logic [2:0] idx;
    logic       wrap;
  } vec_t;

  vec_t sb[$];

  onehot_sequencer #(
    .SEL_W  (3),
    .DWELL  (3),
    .RST_IDX(0)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .EN  (en),
    .LOAD(load),
    .SEL (sel),
    .STEP(step),
    .DIR (dir),
    .RUN (run),
`ifdef ONEHOT_SEQ_THERMO_EN
    .MODE(mode),
`endif
    .X   (x),
    .IDX (idx),
    .WRAP(wrap)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic ld, input logic [2:0] s,
                              input logic st, input logic d, input logic rn, input logic e,
                              input logic m, input logic [7:0] ex, input logic [2:0] ei,
                              input logic ew);
    vec_t v;
    v.rst = r; v.load = ld; v.sel = s; v.step = st; v.dir = d; v.run = rn;
    v.en = e; v.mode = m; v.x = ex; v.idx = ei; v.wrap = ew;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = v.rst; load = v.load; sel = v.sel; step = v.step;
    dir = v.dir; run = v.run; en = v.en; mode = v.mode;
  endtask

  task automatic test_reset();
    vec_t v[$];
    vec_t e;
    v = '{mk(1, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0),
          mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0),
          mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0)};
    foreach (v[i]) begin
      apply(v[i]);
      sb.push_back(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (x !== e.x || idx !== e.idx || wrap !== e.wrap) begin
        errors++;
        $display("FAIL reset[%0d]: got X=%h IDX=%0d WRAP=%b, want X=%h IDX=%0d WRAP=%b",
                 i, x, idx, wrap, e.x, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_step();
    vec_t v[$];
    vec_t e;
    v = '{mk(0, 1, 5, 0, 0, 0, 1, 0, 8'h20, 5, 0),
          mk(0, 0, 0, 1, 0, 0, 1, 0, 8'h40, 6, 0),
          mk(0, 0, 0, 1, 0, 0, 1, 0, 8'h80, 7, 0),
          mk(0, 0, 0, 1, 0, 0, 1, 0, 8'h01, 0, 1),
          mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0),
          mk(0, 1, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0),
          mk(0, 0, 0, 1, 1, 0, 1, 0, 8'h80, 7, 1),
          mk(0, 0, 0, 1, 1, 0, 1, 0, 8'h40, 6, 0),
          mk(0, 0, 0, 1, 0, 0, 1, 0, 8'h80, 7, 0)};
    foreach (v[i]) begin
      apply(v[i]);
      sb.push_back(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (x !== e.x || idx !== e.idx || wrap !== e.wrap) begin
        errors++;
        $display("FAIL step[%0d]: got X=%h IDX=%0d WRAP=%b, want X=%h IDX=%0d WRAP=%b",
                 i, x, idx, wrap, e.x, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_run_dwell();
    vec_t v[$];
    vec_t e;
    v = '{mk(0, 1, 2, 0, 0, 0, 1, 0, 8'h04, 2, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h04, 2, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h04, 2, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h08, 3, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h08, 3, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h08, 3, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h10, 4, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h10, 4, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h10, 4, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h20, 5, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h20, 5, 0),
          mk(0, 1, 1, 0, 0, 1, 1, 0, 8'h02, 1, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h02, 1, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h02, 1, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h04, 2, 0),
          // RUN drop clears the count: a fresh run needs a full dwell again
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h04, 2, 0),
          mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h04, 2, 0),
          mk(0, 0, 0, 0, 1, 1, 1, 0, 8'h04, 2, 0),
          mk(0, 0, 0, 0, 1, 1, 1, 0, 8'h04, 2, 0),
          mk(0, 0, 0, 0, 1, 1, 1, 0, 8'h02, 1, 0),
          mk(0, 1, 7, 0, 0, 0, 1, 0, 8'h80, 7, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h80, 7, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h80, 7, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h01, 0, 1),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h01, 0, 0)};
    foreach (v[i]) begin
      apply(v[i]);
      sb.push_back(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (x !== e.x || idx !== e.idx || wrap !== e.wrap) begin
        errors++;
        $display("FAIL run_dwell[%0d]: got X=%h IDX=%0d WRAP=%b, want X=%h IDX=%0d WRAP=%b",
                 i, x, idx, wrap, e.x, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_priority_en();
    vec_t v[$];
    vec_t e;
    v = '{mk(0, 1, 4, 1, 0, 1, 0, 0, 8'h00, 4, 0),
          mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h10, 4, 0),
          mk(0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 5, 0),
          mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h20, 5, 0),
          mk(0, 1, 7, 0, 0, 0, 0, 0, 8'h00, 7, 0),
          mk(0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 1),
          mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0)};
    foreach (v[i]) begin
      apply(v[i]);
      sb.push_back(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (x !== e.x || idx !== e.idx || wrap !== e.wrap) begin
        errors++;
        $display("FAIL priority_en[%0d]: got X=%h IDX=%0d WRAP=%b, want X=%h IDX=%0d WRAP=%b",
                 i, x, idx, wrap, e.x, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t v[$];
    vec_t e;
    v = '{mk(0, 1, 5, 0, 0, 0, 1, 0, 8'h20, 5, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h20, 5, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h20, 5, 0),
          mk(1, 0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h01, 0, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h01, 0, 0),
          mk(0, 0, 0, 0, 0, 1, 1, 0, 8'h02, 1, 0),
          mk(0, 1, 7, 0, 0, 0, 1, 0, 8'h80, 7, 0),
          mk(1, 1, 3, 1, 0, 1, 1, 0, 8'h00, 0, 0),
          mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0)};
    foreach (v[i]) begin
      apply(v[i]);
      sb.push_back(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (x !== e.x || idx !== e.idx || wrap !== e.wrap) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got X=%h IDX=%0d WRAP=%b, want X=%h IDX=%0d WRAP=%b",
                 i, x, idx, wrap, e.x, e.idx, e.wrap);
      end
    end
  endtask

`ifdef ONEHOT_SEQ_THERMO_EN
  task automatic test_thermo();
    vec_t v[$];
    vec_t e;
    v = '{mk(0, 1, 3, 0, 0, 0, 1, 1, 8'h0F, 3, 0),
          mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h08, 3, 0),
          mk(0, 1, 7, 0, 0, 0, 1, 1, 8'hFF, 7, 0),
          mk(0, 1, 0, 0, 0, 0, 1, 1, 8'h01, 0, 0),
          mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0)};
    foreach (v[i]) begin
      apply(v[i]);
      sb.push_back(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (x !== e.x || idx !== e.idx || wrap !== e.wrap) begin
        errors++;
        $display("FAIL thermo[%0d]: got X=%h IDX=%0d WRAP=%b, want X=%h IDX=%0d WRAP=%b",
                 i, x, idx, wrap, e.x, e.idx, e.wrap);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; step = 1'b0; dir = 1'b0;
    run = 1'b0; mode = 1'b0; sel = '0;
    @(posedge clk); #1;
    test_reset();
    test_step();
    test_run_dwell();
    test_priority_en();
    test_reset_mid();
`ifdef ONEHOT_SEQ_THERMO_EN
    test_thermo();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_sequencer.md
Name: onehot_sequencer

Overview:
- Registered, parametrised successor to the 3-to-8 combinational decoder.
- Holds a SEL_W-bit index register and drives its 2**SEL_W-bit one-hot decode as a registered output.
- The index can be loaded directly, stepped up or down manually, or auto-advanced every DWELL cycles.
- Drives rotating chip selects, scan-line selects and ALU operand-slot strobes.

Parameters:
- SEL_W, 3, index width; output width OUT_W = 2**SEL_W (legal 1..6).
- DWELL, 1, cycles between auto-advances while RUN=1 (legal 1..65535).
- RST_IDX, 0, index value after reset (must be < OUT_W).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- EN  input  1  output enable; 0 forces X to all-zero, index unaffected.
- LOAD  input  1  load SEL into index.
- SEL  input  SEL_W  load value.
- STEP  input  1  single manual advance.
- DIR  input  1  direction: 0 = increment, 1 = decrement (STEP and RUN).
- RUN  input  1  auto-advance enable.
- X  output  OUT_W  registered decode of index (one-hot or all-zero).
- IDX  output  SEL_W  current index register.
- WRAP  output  1  one-cycle pulse on wrap-around.

Behaviour:
- Reset: one clock; reset is synchronous and active-high; ports named CLK and RST.
  - On CLK edge with RST=1: IDX=RST_IDX, dwell counter=0, WRAP=0.
  - X=0 after reset; X is one-hot of RST_IDX only from the first edge with RST=0 and EN=1.
- Priority per edge: RST > LOAD > STEP > RUN tick. Only one index update per cycle.
- LOAD: IDX<=SEL; dwell counter<=0; WRAP<=0.
- STEP (no LOAD): IDX<=IDX±1 per DIR, modulo OUT_W; dwell counter<=0.
- RUN tick:
  - Dwell counter counts 0..DWELL-1 while RUN=1 and no LOAD/STEP.
  - At DWELL-1 the counter returns to 0 and IDX advances per DIR.
  - DWELL=1 advances every cycle.
  - RUN=0 clears the counter; a new RUN run restarts a full dwell.
- Wrap-around:
  - Increment from OUT_W-1 gives 0; decrement from 0 gives OUT_W-1.
  - WRAP=1 for exactly the cycle in which IDX shows the wrapped value; otherwise 0.
- X registered in the same edge as IDX: X[k]=1 iff k==next IDX and EN=1, else 0.
  - Latency from LOAD/STEP sample to X: 1 cycle.
  - X and IDX are always mutually consistent.
- EN low: X=0, sequencing continues; raising EN shows the current index on the next edge.
- DIR may change any cycle; it takes effect on the next advance.
- Reset mid-dwell or mid-sequence: counter and index discarded, no WRAP pulse.

Optional Feature:
- Macro: ONEHOT_SEQ_THERMO_EN.
- Defined:
  - Adds input port MODE (1 bit).
  - MODE=1 makes X a thermometer code: X[k]=1 for all k<=IDX, gated by EN.
  - MODE=0 keeps the one-hot decode.
  - MODE is registered with X, latency 1.
- Undefined: no MODE port; X is always one-hot.

Test Plan:
- Reset with SEL_W=3, RST_IDX=0, EN=1 -> after the RST=1 edge X=0, IDX=0; after the next edge X=8'h01; WRAP stays 0.
- LOAD SEL=5, then STEP DIR=0 three times -> X: 8'h20, 8'h40, 8'h80, 8'h01; IDX 5,6,7,0; WRAP=1 only with IDX=0.
- LOAD 0, STEP DIR=1 -> IDX=7, X=8'h80, WRAP=1 one cycle; second STEP -> IDX=6, WRAP=0.
- DWELL=3, RUN=1, DIR=0 from IDX=2 -> IDX changes every 3 cycles (3,4,5); LOAD 1 mid-dwell -> IDX=1, next advance 3 cycles later.
- LOAD and STEP asserted together with SEL=4 -> IDX=4, no step applied; EN=0 same cycle -> X=0, IDX=4; EN=1 -> X=8'h10.
- With ONEHOT_SEQ_THERMO_EN, MODE=1, IDX=3 -> X=8'h0F; MODE=0 -> X=8'h08 next cycle.
